year_counter: RTL and testbench
===============================

Name: year_counter

Overview:
- 4-digit BCD year counter, range 0000-9999.
- Sits downstream of the month/day date counter: it consumes that counter's end-of-year carry pulse and feeds back the leap-year flag the date counter uses to set the February limit.
- Includes a user set mode for loading the year digit by digit; the display can blink the selected digit.

Parameters:
- RST_D3, 4'd2, thousands digit loaded at reset
- RST_D2, 4'd0, hundreds digit loaded at reset
- RST_D1, 4'd1, tens digit loaded at reset
- RST_D0, 4'd9, ones digit loaded at reset
- Every RST_Dx must be 0-9; elaboration error otherwise.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- carry_in  input  1  single-cycle pulse from date counter on Dec 31 -> Jan 01 rollover
- set_mode  input  1  level; 1 = set mode, 0 = run mode
- set_next  input  1  single-cycle pulse; advance digit selection
- set_inc  input  1  single-cycle pulse; increment selected digit
- digit3_year  output  4  BCD thousands
- digit2_year  output  4  BCD hundreds
- digit1_year  output  4  BCD tens
- digit0_year  output  4  BCD ones
- leapyear  output  1  current year is a leap year (to date counter)
- carry_out  output  1  year wraps 9999 -> 0000 this cycle
- setting  output  1  1 while in SET state
- sel_digit  output  2  selected digit index in SET (3 = thousands ... 0 = ones); 3 in RUN

Behaviour:
- Reset (async, rst_n=0): digits = RST_D3..RST_D0, state = RUN, sel = 3. With defaults, leapyear=0 and carry_out=0.
- FSM, 2 states:
  - RUN -> SET when set_mode=1 at a clock edge; sel loads 3 on entry.
  - SET -> RUN when set_mode=0.
  - setting = (state==SET), registered.
- RUN:
  - carry_in=1 at an edge -> year increments by 1 on that edge (1-cycle latency).
  - Ones 9 -> 0 carries into tens, tens 9 -> 0 into hundreds, and so on.
  - 9999 -> 0000 wraps.
  - set_next and set_inc are ignored.
- carry_out = carry_in & (state==RUN) & (year==9999). It is combinational, asserted in the same cycle as the causing carry_in, for chaining.
- SET:
  - carry_in is ignored and dropped, not queued; carry_out = 0.
  - set_next: sel steps 3 -> 2 -> 1 -> 0 -> 3.
  - set_inc: the selected digit becomes (d+1) mod 10. There is no carry into other digits and no carry_out.
  - set_next and set_inc on the same edge: the increment applies to the old sel, and sel advances on the same edge.
- Transition edge: the state change and the input that caused it take effect on the same edge.
  - On the RUN -> SET edge, carry_in is still honoured (the state is RUN at that edge).
  - On the SET -> RUN edge, set_inc/set_next are still honoured and carry_in is dropped.
- leapyear: combinational from the registered digits.
  - Let lo = {d1,d0} and hi = {d3,d2}, each evaluated BCD-mod-4: a pair is divisible by 4 iff (tens even and ones in {0,4,8}) or (tens odd and ones in {2,6}).
  - If lo != 00: leapyear = lo mod 4 == 0.
  - If lo == 00: leapyear = hi mod 4 == 0.
  - Results: 1900 -> 0, 2000 -> 1, 2024 -> 1, 2019 -> 0, 0000 -> 1.
- Invariant: no digit ever holds a value above 9.
- Reset asserted mid-set: immediate return to RUN with reset digits.

Decomposition:
- Package year_pkg holds:
  - state typedef {RUN, SET}
  - BCD_MAX = 4'd9
  - SEL_MSD = 2'd3
  - bcd_div4 function (2-digit BCD divisibility by 4)
- Sub-module bcd_digit: one mod-10 digit register with inputs inc, async rst_n, and reset value; output wrap (inc & d==9).
  - Instantiated 4 times.
  - Run-mode ripple and set-mode single-digit inc are both driven through its inc input.

Test Plan:
- Reset with defaults, then 1 carry_in pulse -> digits 2,0,1,9 then 2,0,2,0; leapyear goes 0 -> 1 the cycle after the edge; carry_out stays 0.
- Load 1899 via set mode, return to RUN, 1 carry_in -> 1900 with leapyear=0; load 1999 -> 2000 with leapyear=1; 2023 -> 2024 with leapyear=1.
- Load 9999, carry_in pulse -> carry_out=1 in the same cycle, next cycle year 0000 and leapyear=1.
- SET from 2019:
  - set_inc x3 -> 5019.
  - set_next, set_inc -> 5119.
  - set_next x2, set_inc -> 5110 (ones 9 wraps to 0, tens unaffected).
  - sel_digit tracks 3, 2, 0.
- carry_in pulses during SET -> year unchanged and carry_out=0; simultaneous set_next+set_inc with sel=1 -> tens incremented, sel becomes 0.
- rst_n low mid-SET with year 5110 -> immediately 2019, setting=0, sel_digit=3, asynchronously before the next clk edge.

Source files
------------

// File: rtl/year_pkg.sv
// Shared types and helpers for the BCD year counter.
package year_pkg;

   typedef enum logic {
      RUN = 1'b0,
      SET = 1'b1
   } state_t;

   localparam logic [3:0] BCD_MAX = 4'd9;
   localparam logic [1:0] SEL_MSD = 2'd3;

   // Divisibility by 4 of a two-digit BCD number. Only the parity of the tens
   // digit matters, because 10 = 2 (mod 4).
   function automatic logic bcd_div4(input logic [3:0] tens, input logic [3:0] ones);
      logic r;
      if (tens[0]) r = (ones == 4'd2) || (ones == 4'd6);
      else         r = (ones == 4'd0) || (ones == 4'd4) || (ones == 4'd8);
      return r;
   endfunction

endpackage

// File: rtl/year_counter_digit.sv
// One mod-10 BCD digit register. The wrap output flags a 9 -> 0 step.
module bcd_digit
   import year_pkg::*;
#(
   parameter logic [3:0] RST_VAL = 4'd0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       inc,
   output logic [3:0] d,
   output logic       wrap
);

   assign wrap = inc & (d == BCD_MAX);

   // Digit register: step by one on inc, wrapping 9 back to 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)   d <= RST_VAL;
      else if (inc) d <= (d == BCD_MAX) ? 4'd0 : d + 4'd1;
   end

endmodule

// File: rtl/year_counter.sv
// Four-digit BCD year counter with leap-year flag and digit-wise set mode.
// Counts on the date counter's end-of-year pulse; in set mode the user picks a
// digit and steps it without carrying into its neighbours.
module year_counter
   import year_pkg::*;
#(
   parameter logic [3:0] RST_D3 = 4'd2,
   parameter logic [3:0] RST_D2 = 4'd0,
   parameter logic [3:0] RST_D1 = 4'd1,
   parameter logic [3:0] RST_D0 = 4'd9
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       carry_in,
   input  logic       set_mode,
   input  logic       set_next,
   input  logic       set_inc,
   output logic [3:0] digit3_year,
   output logic [3:0] digit2_year,
   output logic [3:0] digit1_year,
   output logic [3:0] digit0_year,
   output logic       leapyear,
   output logic       carry_out,
   output logic       setting,
   output logic [1:0] sel_digit
);

   if ((RST_D3 > BCD_MAX) || (RST_D2 > BCD_MAX) ||
       (RST_D1 > BCD_MAX) || (RST_D0 > BCD_MAX)) begin : g_bad_rst
      $error("year_counter: every RST_Dx must be a BCD digit 0-9");
   end

   state_t     state, state_nxt;
   logic       run_act, set_act;
   logic [1:0] sel;

   // Ripple chain (run mode only) and per-digit set hits.
   logic c0, c1, c2, c3;
   logic s0, s1, s2, s3;
   logic inc0, inc1, inc2, inc3;
   logic wrap0, wrap1, wrap2, wrap3;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= RUN;
      else        state <= state_nxt;
   end

   // Next state follows the set_mode level.
   always_comb begin
      state_nxt = state;
      case (state)
         RUN: if (set_mode)  state_nxt = SET;
         SET: if (!set_mode) state_nxt = RUN;
         default:            state_nxt = RUN;
      endcase
   end

   // State decode; setting comes straight off the state flop.
   always_comb begin
      run_act = (state == RUN);
      set_act = (state == SET);
      setting = set_act;
   end

   // Digit select: parked at the thousands digit outside set mode (which also
   // loads it on entry), steps down and wraps 0 -> 3 on set_next.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                   sel <= SEL_MSD;
      else if (set_act && set_mode) sel <= set_next ? sel - 2'd1 : sel;
      else                          sel <= SEL_MSD;
   end

   assign sel_digit = sel;

   // Run-mode ripple. The wrap outputs only matter when the chain is live, so
   // everything is qualified by c0; set-mode wraps never propagate.
   assign c0 = run_act & carry_in;
   assign c1 = c0 & wrap0;
   assign c2 = c1 & wrap1;
   assign c3 = c2 & wrap2;
   assign carry_out = c3 & wrap3;

   // Set-mode increment lands on the currently selected digit only; on the
   // exit edge the state is still SET, so a set_inc there is honoured.
   assign s0 = set_act & set_inc & (sel == 2'd0);
   assign s1 = set_act & set_inc & (sel == 2'd1);
   assign s2 = set_act & set_inc & (sel == 2'd2);
   assign s3 = set_act & set_inc & (sel == 2'd3);

   assign inc0 = c0 | s0;
   assign inc1 = c1 | s1;
   assign inc2 = c2 | s2;
   assign inc3 = c3 | s3;

   bcd_digit #(.RST_VAL(RST_D0)) u_d0 (
      .clk(clk), .rst_n(rst_n), .inc(inc0), .d(digit0_year), .wrap(wrap0));
   bcd_digit #(.RST_VAL(RST_D1)) u_d1 (
      .clk(clk), .rst_n(rst_n), .inc(inc1), .d(digit1_year), .wrap(wrap1));
   bcd_digit #(.RST_VAL(RST_D2)) u_d2 (
      .clk(clk), .rst_n(rst_n), .inc(inc2), .d(digit2_year), .wrap(wrap2));
   bcd_digit #(.RST_VAL(RST_D3)) u_d3 (
      .clk(clk), .rst_n(rst_n), .inc(inc3), .d(digit3_year), .wrap(wrap3));

   // Leap year: a century year (lo == 00) defers to the century pair.
   always_comb begin
      if ((digit1_year == 4'd0) && (digit0_year == 4'd0))
         leapyear = bcd_div4(digit3_year, digit2_year);
      else
         leapyear = bcd_div4(digit1_year, digit0_year);
   end

endmodule

// File: tb/tb_year_counter.sv
// Directed, table-driven bench for year_counter.
module tb_year_counter;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       carry_in = 1'b0, set_mode = 1'b0, set_next = 1'b0, set_inc = 1'b0;
   logic [3:0] d3, d2, d1, d0;
   logic       leapyear, carry_out, setting;
   logic [1:0] sel_digit;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   year_counter dut (
      .clk(clk), .rst_n(rst_n), .carry_in(carry_in), .set_mode(set_mode),
      .set_next(set_next), .set_inc(set_inc),
      .digit3_year(d3), .digit2_year(d2), .digit1_year(d1), .digit0_year(d0),
      .leapyear(leapyear), .carry_out(carry_out), .setting(setting),
      .sel_digit(sel_digit));

   // One vector: optional reset pulse, inputs held for rep edges,
   // carry_out expected before the first edge, state expected after the last.
   typedef struct {
      logic        rst;
      logic        sm, sn, si, ci;
      int          rep;
      logic        co;
      logic [15:0] yr;
      logic        leap, setting;
      logic [1:0]  sel;
   } vec_t;

   localparam int NA = 43;  // vectors before the async-reset sequence
   localparam int NV = 50;
   vec_t tbl[NV];

   function automatic vec_t v(int rst, int sm, int sn, int si, int ci, int rep,
                              int co, logic [15:0] yr, int leap, int st, int sel);
      vec_t r;
      r.rst = (rst != 0); r.sm = (sm != 0); r.sn = (sn != 0); r.si = (si != 0);
      r.ci = (ci != 0); r.rep = rep; r.co = (co != 0); r.yr = yr;
      r.leap = (leap != 0); r.setting = (st != 0); r.sel = 2'(sel);
      return r;
   endfunction

   task automatic check_state(input string name, input int idx, input logic [15:0] yr,
                              input logic leap, input logic st, input logic [1:0] sel);
      checks++;
      if ({d3, d2, d1, d0, leapyear, setting, sel_digit} !== {yr, leap, st, sel}) begin
         errors++;
         $display("FAIL %s[%0d]: got year=%h leap=%b setting=%b sel=%0d, expected year=%h leap=%b setting=%b sel=%0d",
                  name, idx, {d3, d2, d1, d0}, leapyear, setting, sel_digit, yr, leap, st, sel);
      end
   endtask

   task automatic check_co(input string name, input int idx, input logic exp);
      checks++;
      if (carry_out !== exp) begin
         errors++;
         $display("FAIL %s[%0d]: got carry_out=%b, expected %b", name, idx, carry_out, exp);
      end
   endtask

   task automatic clear_inputs();
      carry_in = 1'b0; set_mode = 1'b0; set_next = 1'b0; set_inc = 1'b0;
   endtask

   // Called just after a falling edge.
   task automatic apply(input vec_t t, input int idx);
      if (t.rst) begin
         clear_inputs();
         rst_n = 1'b0;
         @(negedge clk);
         rst_n = 1'b1;
      end
      set_mode = t.sm; set_next = t.sn; set_inc = t.si; carry_in = t.ci;
      #1 check_co("carry_out", idx, t.co);
      repeat (t.rep) @(posedge clk);
      #1 check_state("vec", idx, t.yr, t.leap, t.setting, t.sel);
      @(negedge clk);
      clear_inputs();
   endtask

   initial begin
      //          rst sm sn si ci rep co  year     leap set sel
      tbl[0]  = v(0, 0, 0, 0, 1, 1, 0, 16'h2020, 1, 0, 3);
      tbl[1]  = v(0, 1, 0, 0, 0, 1, 0, 16'h2020, 1, 1, 3);
      tbl[2]  = v(0, 1, 0, 1, 0, 9, 0, 16'h1020, 1, 1, 3);
      tbl[3]  = v(0, 1, 1, 0, 0, 1, 0, 16'h1020, 1, 1, 2);
      tbl[4]  = v(0, 1, 0, 1, 0, 8, 0, 16'h1820, 1, 1, 2);
      tbl[5]  = v(0, 1, 1, 0, 0, 1, 0, 16'h1820, 1, 1, 1);
      tbl[6]  = v(0, 1, 0, 1, 0, 7, 0, 16'h1890, 0, 1, 1);
      tbl[7]  = v(0, 1, 1, 0, 0, 1, 0, 16'h1890, 0, 1, 0);
      tbl[8]  = v(0, 1, 0, 1, 0, 9, 0, 16'h1899, 0, 1, 0);
      tbl[9]  = v(0, 0, 0, 0, 0, 1, 0, 16'h1899, 0, 0, 3);
      tbl[10] = v(0, 0, 0, 0, 1, 1, 0, 16'h1900, 0, 0, 3);
      tbl[11] = v(0, 1, 0, 0, 0, 1, 0, 16'h1900, 0, 1, 3);
      tbl[12] = v(0, 1, 1, 0, 0, 2, 0, 16'h1900, 0, 1, 1);
      tbl[13] = v(0, 1, 0, 1, 0, 9, 0, 16'h1990, 0, 1, 1);
      tbl[14] = v(0, 1, 1, 0, 0, 1, 0, 16'h1990, 0, 1, 0);
      tbl[15] = v(0, 1, 0, 1, 0, 9, 0, 16'h1999, 0, 1, 0);
      tbl[16] = v(0, 0, 0, 0, 0, 1, 0, 16'h1999, 0, 0, 3);
      tbl[17] = v(0, 0, 0, 0, 1, 1, 0, 16'h2000, 1, 0, 3);
      tbl[18] = v(0, 1, 0, 0, 0, 1, 0, 16'h2000, 1, 1, 3);
      tbl[19] = v(0, 1, 1, 0, 0, 2, 0, 16'h2000, 1, 1, 1);
      tbl[20] = v(0, 1, 0, 1, 0, 2, 0, 16'h2020, 1, 1, 1);
      tbl[21] = v(0, 1, 1, 0, 0, 1, 0, 16'h2020, 1, 1, 0);
      tbl[22] = v(0, 1, 0, 1, 0, 3, 0, 16'h2023, 0, 1, 0);
      tbl[23] = v(0, 0, 0, 0, 0, 1, 0, 16'h2023, 0, 0, 3);
      tbl[24] = v(0, 0, 0, 0, 1, 1, 0, 16'h2024, 1, 0, 3);
      tbl[25] = v(0, 1, 0, 0, 0, 1, 0, 16'h2024, 1, 1, 3);
      tbl[26] = v(0, 1, 0, 1, 0, 7, 0, 16'h9024, 1, 1, 3);
      tbl[27] = v(0, 1, 1, 0, 0, 1, 0, 16'h9024, 1, 1, 2);
      tbl[28] = v(0, 1, 0, 1, 0, 9, 0, 16'h9924, 1, 1, 2);
      tbl[29] = v(0, 1, 1, 0, 0, 1, 0, 16'h9924, 1, 1, 1);
      tbl[30] = v(0, 1, 0, 1, 0, 7, 0, 16'h9994, 0, 1, 1);
      tbl[31] = v(0, 1, 1, 0, 0, 1, 0, 16'h9994, 0, 1, 0);
      tbl[32] = v(0, 1, 0, 1, 0, 5, 0, 16'h9999, 0, 1, 0);
      tbl[33] = v(0, 1, 0, 0, 1, 2, 0, 16'h9999, 0, 1, 0);  // carry dropped in SET
      tbl[34] = v(0, 0, 0, 0, 0, 1, 0, 16'h9999, 0, 0, 3);
      tbl[35] = v(0, 0, 0, 0, 1, 1, 1, 16'h0000, 1, 0, 3);  // 9999 wraps
      tbl[36] = v(1, 1, 0, 0, 0, 1, 0, 16'h2019, 0, 1, 3);
      tbl[37] = v(0, 1, 0, 1, 0, 3, 0, 16'h5019, 0, 1, 3);
      tbl[38] = v(0, 1, 1, 0, 0, 1, 0, 16'h5019, 0, 1, 2);
      tbl[39] = v(0, 1, 0, 1, 0, 1, 0, 16'h5119, 0, 1, 2);
      tbl[40] = v(0, 1, 1, 0, 0, 2, 0, 16'h5119, 0, 1, 0);
      tbl[41] = v(0, 1, 0, 1, 0, 1, 0, 16'h5110, 0, 1, 0);  // ones wrap, no carry
      tbl[42] = v(0, 1, 0, 0, 1, 3, 0, 16'h5110, 0, 1, 0);
      tbl[43] = v(0, 1, 0, 0, 0, 1, 0, 16'h2019, 0, 1, 3);
      tbl[44] = v(0, 1, 1, 0, 0, 2, 0, 16'h2019, 0, 1, 1);
      tbl[45] = v(0, 1, 1, 1, 0, 1, 0, 16'h2029, 0, 1, 0);  // inc old sel, then advance
      tbl[46] = v(0, 0, 0, 1, 0, 1, 0, 16'h2020, 1, 0, 3);  // inc on SET->RUN edge
      tbl[47] = v(0, 1, 0, 0, 1, 1, 0, 16'h2021, 0, 1, 3);  // carry on RUN->SET edge
      tbl[48] = v(0, 0, 0, 0, 1, 1, 0, 16'h2021, 0, 0, 3);  // carry dropped on exit
      tbl[49] = v(0, 0, 1, 1, 0, 1, 0, 16'h2021, 0, 0, 3);  // set pulses ignored in RUN

      // Reset state with default digits.
      clear_inputs();
      rst_n = 1'b0;
      @(negedge clk);
      #1 check_state("reset", 0, 16'h2019, 1'b0, 1'b0, 2'd3);
      check_co("reset_co", 0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      #1 check_state("reset_release", 0, 16'h2019, 1'b0, 1'b0, 2'd3);
      @(negedge clk);

      for (int i = 0; i < NA; i++) apply(tbl[i], i);

      // Asynchronous reset in the middle of SET at 5110: takes effect before
      // any clock edge.
      #2 rst_n = 1'b0;
      #1 check_state("async_reset", 0, 16'h2019, 1'b0, 1'b0, 2'd3);
      check_co("async_reset_co", 0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = NA; i < NV; i++) apply(tbl[i], i);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
